// File: rtl/mem_access_unit.sv
// Byte-addressed load/store front-end for a word SRAM; splits word-crossing accesses (MEM_MISALIGN_SPLIT_EN).
// Latency: (WAIT_CYCLES+1)*accesses + 1 cycles from accept to rsp_valid; error requests respond after 1 cycle.
// Backpressure: req_ready is high only in IDLE; req_valid while busy is ignored.
module mem_access_unit #(
    parameter int WORD_ADDR_BITS = 14,
    parameter int WAIT_CYCLES    = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_we,
    input  logic [2:0]                req_funct3,
    input  logic [31:0]               req_addr,
    input  logic [31:0]               req_wdata,
    output logic                      rsp_valid,
    output logic [31:0]               rsp_rdata,
    output logic                      rsp_err,
    output logic [WORD_ADDR_BITS-1:0] sram_addr,
    output logic                      sram_read,
    output logic [3:0]                sram_write,
    output logic [31:0]               sram_di,
    input  logic [31:0]               sram_do
);

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

    state_t                    state;
    logic [3:0]                wcnt;
    logic                      lat_we;
    logic [2:0]                lat_f3;
    logic [1:0]                lat_off;
    logic [WORD_ADDR_BITS-1:0] lat_word;
    logic [7:0]                lat_mask;   // byte enables across {ACC1 word, ACC0 word}
    logic [63:0]               lat_data;   // write data across {ACC1 word, ACC0 word}
    logic [31:0]               lo_word;    // first word of a split load

    logic [7:0]                req_base;
    logic [7:0]                req_mask;
    logic [63:0]               req_data;
    logic                      req_f3_bad;
    logic                      req_misalign;
    logic                      req_bad;
    logic [3:0]                cur_mask;
    logic [63:0]               load_cat;
    logic [31:0]               load_sh;
    logic [31:0]               load_val;
    logic                      unused_addr_bits;

    // Address bits above the word index do not select anything.
    assign unused_addr_bits = ^req_addr[31:WORD_ADDR_BITS+2];

    // Decode the incoming request: legality, lane mask and lane-shifted data over two words.
    always_comb begin
        req_base = 8'h0F;
        case (req_funct3[1:0])
            2'b00:   req_base = 8'h01;
            2'b01:   req_base = 8'h03;
            default: req_base = 8'h0F;
        endcase
        req_mask = req_base << req_addr[1:0];
        req_data = {32'b0, req_wdata} << {req_addr[1:0], 3'b000};

        if (req_we)
            req_f3_bad = (req_funct3 > 3'b010);
        else
            req_f3_bad = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);

`ifdef MEM_MISALIGN_SPLIT_EN
        req_misalign = 1'b0;
`else
        req_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`endif
        req_bad = req_f3_bad || req_misalign;
    end

    // Align and extend load data from {hi, lo} words of the current access.
    always_comb begin
        cur_mask = (state == ACC1) ? lat_mask[7:4] : lat_mask[3:0];
        load_cat = (state == ACC1) ? {sram_do, lo_word} : {32'b0, sram_do};
        load_sh  = 32'(load_cat >> {lat_off, 3'b000});
        case (lat_f3)
            3'b000:  load_val = {{24{load_sh[7]}}, load_sh[7:0]};
            3'b001:  load_val = {{16{load_sh[15]}}, load_sh[15:0]};
            3'b010:  load_val = load_sh;
            3'b100:  load_val = {24'b0, load_sh[7:0]};
            3'b101:  load_val = {16'b0, load_sh[15:0]};
            default: load_val = 32'b0;
        endcase
    end

    // Control FSM; every output is registered and set up one cycle ahead of its state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            wcnt       <= 4'd0;
            lat_we     <= 1'b0;
            lat_f3     <= 3'b0;
            lat_off    <= 2'b0;
            lat_word   <= '0;
            lat_mask   <= 8'b0;
            lat_data   <= 64'b0;
            lo_word    <= 32'b0;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= 32'b0;
            rsp_err    <= 1'b0;
            sram_addr  <= '0;
            sram_read  <= 1'b0;
            sram_write <= 4'b0;
            sram_di    <= 32'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_we    <= req_we;
                        lat_f3    <= req_funct3;
                        lat_off   <= req_addr[1:0];
                        lat_word  <= req_addr[WORD_ADDR_BITS+1:2];
                        lat_mask  <= req_mask;
                        lat_data  <= req_data;
                        req_ready <= 1'b0;
                        if (req_bad) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= 32'b0;
                        end else begin
                            state      <= ACC0;
                            wcnt       <= 4'd0;
                            sram_addr  <= req_addr[WORD_ADDR_BITS+1:2];
                            sram_read  <= !req_we;
                            sram_write <= (req_we && (WAIT_LAST == 4'd0)) ? req_mask[3:0] : 4'b0;
                            sram_di    <= req_data[31:0];
                        end
                    end
                end
                ACC0, ACC1: begin
                    if (wcnt != WAIT_LAST) begin
                        // Strobe fires only in the final cycle of the access.
                        wcnt       <= 4'(wcnt + 4'd1);
                        sram_write <= (lat_we && (4'(wcnt + 4'd1) == WAIT_LAST)) ? cur_mask : 4'b0;
                    end else if ((state == ACC0) && (lat_mask[7:4] != 4'b0)) begin
                        state      <= ACC1;
                        wcnt       <= 4'd0;
                        lo_word    <= sram_do;
                        sram_addr  <= lat_word + WORD_ADDR_BITS'(1);
                        sram_write <= (lat_we && (WAIT_LAST == 4'd0)) ? lat_mask[7:4] : 4'b0;
                        sram_di    <= lat_data[63:32];
                    end else begin
                        state      <= RESP;
                        sram_read  <= 1'b0;
                        sram_write <= 4'b0;
                        rsp_valid  <= 1'b1;
                        rsp_err    <= 1'b0;
                        rsp_rdata  <= lat_we ? 32'b0 : load_val;
                    end
                end
                default: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    rsp_rdata <= 32'b0;
                    rsp_err   <= 1'b0;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: one zero-wait instance with an SRAM model, one 3-wait instance with a ROM.
// Latency is counted in cycles after the accept edge, sampled on the falling edge.
// Requests are issued only when req_ready is observed high.
module tb_mem_access_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Zero-wait instance
    logic        rst, req_valid, req_ready, req_we, rsp_valid, rsp_err, sram_read;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata, rsp_rdata, sram_di, sram_do;
    logic [13:0] sram_addr;
    logic [3:0]  sram_write;
    logic [31:0] mem [0:16383];

    // Three-wait instance
    logic        rst_3, req_valid_3, req_ready_3, req_we_3, rsp_valid_3, rsp_err_3, sram_read_3;
    logic [2:0]  req_funct3_3;
    logic [31:0] req_addr_3, req_wdata_3, rsp_rdata_3, sram_di_3, sram_do_3;
    logic [13:0] sram_addr_3;
    logic [3:0]  sram_write_3;

    mem_access_unit #(.WORD_ADDR_BITS(14), .WAIT_CYCLES(0)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .sram_addr(sram_addr), .sram_read(sram_read), .sram_write(sram_write),
        .sram_di(sram_di), .sram_do(sram_do)
    );

    mem_access_unit #(.WORD_ADDR_BITS(14), .WAIT_CYCLES(3)) u_dut_3 (
        .clk(clk), .rst(rst_3), .req_valid(req_valid_3), .req_ready(req_ready_3), .req_we(req_we_3),
        .req_funct3(req_funct3_3), .req_addr(req_addr_3), .req_wdata(req_wdata_3),
        .rsp_valid(rsp_valid_3), .rsp_rdata(rsp_rdata_3), .rsp_err(rsp_err_3),
        .sram_addr(sram_addr_3), .sram_read(sram_read_3), .sram_write(sram_write_3),
        .sram_di(sram_di_3), .sram_do(sram_do_3)
    );

    // Byte-writable SRAM with combinational read
    assign sram_do = mem[sram_addr];
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (sram_write[i]) mem[sram_addr][8*i +: 8] <= sram_di[8*i +: 8];
    end

    // Address-derived ROM for the wait-state instance
    assign sram_do_3 = {18'h0, sram_addr_3} ^ 32'h5A5A0000;

    // Event counters for the wait-state instance
    int wr3_cnt = 0;
    int rsp3_cnt = 0;
    always @(negedge clk) begin
        if (sram_write_3 != 4'b0) wr3_cnt <= wr3_cnt + 1;
        if (rsp_valid_3) rsp3_cnt <= rsp3_cnt + 1;
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    // Write/read trace of the last request on the zero-wait instance
    int          nwr, nrd;
    logic [13:0] wa [4];
    logic [3:0]  wm [4];
    logic [31:0] wd [4];

    task automatic sample_trace();
        if (sram_write != 4'b0) begin
            if (nwr < 4) begin
                wa[nwr] = sram_addr;
                wm[nwr] = sram_write;
                wd[nwr] = sram_di;
            end
            nwr++;
        end
        if (sram_read) nrd++;
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata,
                          output logic err, output int lat);
        int guard;
        nwr = 0;
        nrd = 0;
        guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        sample_trace();
        while (!rsp_valid && lat < 50) begin
            @(negedge clk);
            lat++;
            sample_trace();
        end
        if (!rsp_valid) check("rsp_timeout", {31'b0, rsp_valid}, 32'd1);
        rdata = rsp_rdata;
        err = rsp_err;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    logic [31:0] rd;
    logic        er;
    int          lt;
    int          base_wr, base_rsp, reads, bad_addr, wpulses, wlat;

    initial begin
        rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0; req_addr = 32'b0; req_wdata = 32'b0;
        rst_3 = 1'b0; req_valid_3 = 1'b0; req_we_3 = 1'b0; req_funct3_3 = 3'b0; req_addr_3 = 32'b0; req_wdata_3 = 32'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
        check("rst_sram_read", {31'b0, sram_read}, 32'd0);
        check("rst_sram_write", {28'b0, sram_write}, 32'd0);
        check("rst_sram_addr", {18'b0, sram_addr}, 32'd0);
        check("rst_sram_di", sram_di, 32'd0);
        rst = 1'b1; rst_3 = 1'b1;
        @(negedge clk);
        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst3_req_ready", {31'b0, req_ready_3}, 32'd1);

        // SW aligned
        do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, er, lt);
        check("sw_lat", lt, 32'd2);
        check("sw_err", {31'b0, er}, 32'd0);
        check("sw_rdata", rd, 32'd0);
        check("sw_nwr", nwr, 32'd1);
        check("sw_addr", {18'b0, wa[0]}, 32'd4);
        check("sw_mask", {28'b0, wm[0]}, 32'hF);
        check("sw_di", wd[0], 32'hDEADBEEF);

        // SB lane 3, then signed/unsigned byte loads
        do_req(1'b1, 3'b000, 32'h13, 32'h000000A5, rd, er, lt);
        check("sb_addr", {18'b0, wa[0]}, 32'd4);
        check("sb_mask", {28'b0, wm[0]}, 32'h8);
        check("sb_di", wd[0], 32'hA5000000);
        do_req(1'b0, 3'b000, 32'h13, 32'h0, rd, er, lt);
        check("lb_rdata", rd, 32'hFFFFFFA5);
        check("lb_lat", lt, 32'd2);
        check("lb_nrd", nrd, 32'd1);
        do_req(1'b0, 3'b100, 32'h13, 32'h0, rd, er, lt);
        check("lbu_rdata", rd, 32'h000000A5);

        // Halfword loads
        do_req(1'b1, 3'b010, 32'h10, 32'h80017FFF, rd, er, lt);
        do_req(1'b0, 3'b001, 32'h12, 32'h0, rd, er, lt);
        check("lh_hi", rd, 32'hFFFF8001);
        do_req(1'b0, 3'b101, 32'h12, 32'h0, rd, er, lt);
        check("lhu_hi", rd, 32'h00008001);
        do_req(1'b0, 3'b001, 32'h10, 32'h0, rd, er, lt);
        check("lh_lo", rd, 32'h00007FFF);
        do_req(1'b1, 3'b001, 32'h12, 32'h0000BEEF, rd, er, lt);
        check("sh_mask", {28'b0, wm[0]}, 32'hC);
        check("sh_di", wd[0], 32'hBEEF0000);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lt);
        check("lw_after_sh", rd, 32'hBEEF7FFF);

`ifdef MEM_MISALIGN_SPLIT_EN
        // Word-crossing store and load
        do_req(1'b1, 3'b010, 32'h0E, 32'h11223344, rd, er, lt);
        check("split_sw_lat", lt, 32'd3);
        check("split_sw_err", {31'b0, er}, 32'd0);
        check("split_sw_nwr", nwr, 32'd2);
        check("split_a0", {18'b0, wa[0]}, 32'd3);
        check("split_m0", {28'b0, wm[0]}, 32'hC);
        check("split_d0", wd[0], 32'h33440000);
        check("split_a1", {18'b0, wa[1]}, 32'd4);
        check("split_m1", {28'b0, wm[1]}, 32'h3);
        check("split_d1", wd[1], 32'h00001122);
        do_req(1'b0, 3'b010, 32'h0E, 32'h0, rd, er, lt);
        check("split_lw", rd, 32'h11223344);
        check("split_lw_lat", lt, 32'd3);
        check("split_lw_nrd", nrd, 32'd2);
        do_req(1'b0, 3'b001, 32'h11, 32'h0, rd, er, lt);
        check("inword_lh", rd, 32'hFFFFEF11);
        check("inword_lh_lat", lt, 32'd2);
        // Top word wraps to word 0; upper address bits ignored
        do_req(1'b1, 3'b010, 32'h0001FFFE, 32'hCAFEF00D, rd, er, lt);
        check("wrap_a0", {18'b0, wa[0]}, 32'h3FFF);
        check("wrap_d0", wd[0], 32'hF00D0000);
        check("wrap_a1", {18'b0, wa[1]}, 32'd0);
        check("wrap_m1", {28'b0, wm[1]}, 32'h3);
        check("wrap_d1", wd[1], 32'h0000CAFE);
        do_req(1'b0, 3'b010, 32'h0000FFFE, 32'h0, rd, er, lt);
        check("wrap_lw", rd, 32'hCAFEF00D);
`else
        // Misaligned halfword/word rejected without SRAM activity
        do_req(1'b1, 3'b010, 32'h0E, 32'h11223344, rd, er, lt);
        check("mis_sw_err", {31'b0, er}, 32'd1);
        check("mis_sw_lat", lt, 32'd1);
        check("mis_sw_nwr", nwr, 32'd0);
        do_req(1'b0, 3'b001, 32'h11, 32'h0, rd, er, lt);
        check("mis_lh_err", {31'b0, er}, 32'd1);
        check("mis_lh_nrd", nrd, 32'd0);
        check("mis_lh_rdata", rd, 32'd0);
        do_req(1'b0, 3'b010, 32'h12, 32'h0, rd, er, lt);
        check("mis_lw_err", {31'b0, er}, 32'd1);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lt);
        check("mis_lw_unchanged", rd, 32'hBEEF7FFF);
`endif

        // Illegal funct3
        do_req(1'b0, 3'b011, 32'h20, 32'h0, rd, er, lt);
        check("ill_ld_err", {31'b0, er}, 32'd1);
        check("ill_ld_rdata", rd, 32'd0);
        check("ill_ld_lat", lt, 32'd1);
        check("ill_ld_nrd", nrd, 32'd0);
        do_req(1'b1, 3'b100, 32'h20, 32'hFFFFFFFF, rd, er, lt);
        check("ill_st_err", {31'b0, er}, 32'd1);
        check("ill_st_nwr", nwr, 32'd0);
        do_req(1'b0, 3'b110, 32'h20, 32'h0, rd, er, lt);
        check("ill_ld110_err", {31'b0, er}, 32'd1);

        // Wait-state instance: LW holds read and address for 4 cycles
        @(negedge clk);
        req_valid_3 = 1'b1; req_we_3 = 1'b0; req_funct3_3 = 3'b010; req_addr_3 = 32'h40;
        @(posedge clk);
        @(negedge clk);
        req_valid_3 = 1'b0;
        lt = 1; reads = 0; bad_addr = 0;
        while (!rsp_valid_3 && lt < 50) begin
            if (sram_read_3) reads++;
            if (sram_addr_3 != 14'h10) bad_addr++;
            @(negedge clk);
            lt++;
        end
        check("w3_lw_lat", lt, 32'd5);
        check("w3_lw_reads", reads, 32'd4);
        check("w3_lw_addr_stable", bad_addr, 32'd0);
        check("w3_lw_rdata", rsp_rdata_3, 32'h5A5A0010);
        check("w3_lw_err", {31'b0, rsp_err_3}, 32'd0);

        // Wait-state instance: SW strobes once, in the last access cycle
        @(negedge clk);
        @(negedge clk);
        req_valid_3 = 1'b1; req_we_3 = 1'b1; req_funct3_3 = 3'b010; req_addr_3 = 32'h44; req_wdata_3 = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        req_valid_3 = 1'b0;
        lt = 1; wpulses = 0; wlat = 0;
        while (!rsp_valid_3 && lt < 50) begin
            if (sram_write_3 != 4'b0) begin
                wpulses++;
                wlat = lt;
                check("w3_sw_di", sram_di_3, 32'h12345678);
                check("w3_sw_read", {31'b0, sram_read_3}, 32'd0);
            end
            @(negedge clk);
            lt++;
        end
        check("w3_sw_pulses", wpulses, 32'd1);
        check("w3_sw_pulse_cycle", wlat, 32'd4);
        check("w3_sw_lat", lt, 32'd5);

        // Reset during the second wait cycle abandons the store
        @(negedge clk);
        @(negedge clk);
        req_valid_3 = 1'b1; req_we_3 = 1'b1; req_funct3_3 = 3'b010; req_addr_3 = 32'h48; req_wdata_3 = 32'hA5A5A5A5;
        @(posedge clk);
        @(negedge clk);
        req_valid_3 = 1'b0;
        base_wr = wr3_cnt;
        base_rsp = rsp3_cnt;
        check("w3_busy_ready", {31'b0, req_ready_3}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_3 = 1'b0;
        @(negedge clk);
        check("w3_rst_write", {28'b0, sram_write_3}, 32'd0);
        rst_3 = 1'b1;
        @(negedge clk);
        check("w3_ready_after_rst", {31'b0, req_ready_3}, 32'd1);
        repeat (8) @(negedge clk);
        check("w3_rst_no_write", wr3_cnt - base_wr, 32'd0);
        check("w3_rst_no_rsp", rsp3_cnt - base_rsp, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
